// File: rtl/pipe_scroll_ctrl.sv
// Pipe scroll controller: scrolls NUM_PIPES pipe slots left once per frame and issues
// erase/draw requests to the pipe drawer over an enable/done handshake.
module pipe_scroll_ctrl #(
    parameter int NUM_PIPES = 3,
    parameter int SCREEN_W  = 640,
    parameter int PIPE_W    = 70,
    parameter int SPACING   = 240,
    parameter int SPEED     = 1,
    parameter int Y_MIN     = 160,
    parameter int BIRD_X    = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        run,
    input  logic [7:0]  rand_in,
    output logic        draw_en,
    input  logic        draw_done,
    output logic [10:0] pipe_x,
    output logic [10:0] pipe_y,
    output logic        pix_color,
    output logic        busy,
    output logic        frame_done,
    output logic        pass_pulse,
    output logic        overrun
);

    localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

    localparam logic [10:0]      VIS_LIMIT = 11'(SCREEN_W + PIPE_W);
    localparam logic [10:0]      STEP      = 11'(SPEED);
    localparam logic [10:0]      WRAP_ADD  = 11'(NUM_PIPES * SPACING - SPEED);
    localparam logic [10:0]      Y_BASE    = 11'(Y_MIN);
    localparam logic [10:0]      BIRD_POS  = 11'(BIRD_X);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PIPES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_MOVE,
        S_DRAW,
        S_NEXT,
        S_FIN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [10:0]      slot_x [NUM_PIPES];
    logic [10:0]      slot_y [NUM_PIPES];

    logic [10:0] cur_x, cur_y, new_x, new_y;
    logic        wrap;

    function automatic logic visible(input logic [10:0] x);
        return x < VIS_LIMIT;
    endfunction

    // The wrap test guards the subtraction, so x never underflows.
    always_comb begin
        cur_x = slot_x[idx];
        cur_y = slot_y[idx];
        wrap  = cur_x < STEP;
        new_x = wrap ? cur_x + WRAP_ADD : cur_x - STEP;
        new_y = wrap ? Y_BASE + {3'b000, rand_in} : cur_y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            draw_en    <= 1'b0;
            pipe_x     <= '0;
            pipe_y     <= '0;
            pix_color  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pass_pulse <= 1'b0;
            overrun    <= 1'b0;
            // NOTE: the slot registers are game state with defined start positions, so they are reset.
            for (int i = 0; i < NUM_PIPES; i++) begin
                slot_x[i] <= 11'(SCREEN_W + PIPE_W + i * SPACING);
                slot_y[i] <= 11'(Y_MIN + 80 * i);
            end
        end else begin
            // NOTE: pulse outputs default low here and are raised only in the cycle they fire.
            frame_done <= 1'b0;
            pass_pulse <= 1'b0;
            overrun    <= frame_start && busy;
            case (state)
                S_IDLE: begin
                    if (frame_start && run) begin
                        busy  <= 1'b1;
                        idx   <= '0;
                        state <= S_ERASE;
                    end
                end
                S_ERASE: begin
                    if (!draw_en) begin
                        if (visible(cur_x)) begin
                            pipe_x    <= cur_x;
                            pipe_y    <= cur_y;
                            pix_color <= 1'b0;
                            draw_en   <= 1'b1;
                        end else begin
                            state <= S_MOVE;
                        end
                    end else if (draw_done) begin
                        draw_en <= 1'b0;
                        state   <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    slot_x[idx] <= new_x;
                    slot_y[idx] <= new_y;
                    if (cur_x >= BIRD_POS && new_x < BIRD_POS) pass_pulse <= 1'b1;
                    if (visible(new_x)) begin
                        pipe_x    <= new_x;
                        pipe_y    <= new_y;
                        pix_color <= 1'b1;
                        draw_en   <= 1'b1;
                        state     <= S_DRAW;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_DRAW: begin
                    if (draw_done) begin
                        draw_en <= 1'b0;
                        state   <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (idx == LAST_IDX) begin
                        state <= S_FIN;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= S_ERASE;
                    end
                end
                S_FIN: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_scroll_ctrl.sv
// Directed bench for pipe_scroll_ctrl: a default instance and a SPEED=10 instance share stimulus,
// each served by a drawer model that answers 5 cycles after a request and a request logger.
module tb_pipe_scroll_ctrl;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        c;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       run = 1'b1;
    logic [7:0] rand_in = 8'h20;

    logic        draw_en_d, draw_done_d = 1'b0, pix_color_d, busy_d, frame_done_d, pass_pulse_d, overrun_d;
    logic [10:0] pipe_x_d, pipe_y_d;
    logic        draw_en_f, draw_done_f = 1'b0, pix_color_f, busy_f, frame_done_f, pass_pulse_f, overrun_f;
    logic [10:0] pipe_x_f, pipe_y_f;

    int checks = 0;
    int failures = 0;

    pipe_scroll_ctrl u_def (
        .clk(clk), .reset(reset), .frame_start(frame_start), .run(run), .rand_in(rand_in),
        .draw_en(draw_en_d), .draw_done(draw_done_d), .pipe_x(pipe_x_d), .pipe_y(pipe_y_d),
        .pix_color(pix_color_d), .busy(busy_d), .frame_done(frame_done_d),
        .pass_pulse(pass_pulse_d), .overrun(overrun_d)
    );

    pipe_scroll_ctrl #(.SPEED(10)) u_fast (
        .clk(clk), .reset(reset), .frame_start(frame_start), .run(run), .rand_in(rand_in),
        .draw_en(draw_en_f), .draw_done(draw_done_f), .pipe_x(pipe_x_f), .pipe_y(pipe_y_f),
        .pix_color(pix_color_f), .busy(busy_f), .frame_done(frame_done_f),
        .pass_pulse(pass_pulse_f), .overrun(overrun_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input int x, input int y, input int c);
        req_t r;
        r.x = 11'(x);
        r.y = 11'(y);
        r.c = 1'(c);
        return r;
    endfunction

    // Drawer model and request logger, default instance
    req_t log_d[$];
    req_t held_d;
    int   cnt_d = 0, fd_d = 0, pass_d = 0, ovr_d = 0;
    logic en_prev_d = 1'b0, done_prev_d = 1'b0;

    always @(negedge clk) begin
        if (done_prev_d) check("def_en_drop_after_done", 32'(draw_en_d), 32'd0);
        if (draw_en_d && en_prev_d) check("def_req_stable", 32'({pipe_x_d, pipe_y_d, pix_color_d}), 32'(held_d));
        if (draw_en_d && !en_prev_d) begin
            held_d = {pipe_x_d, pipe_y_d, pix_color_d};
            log_d.push_back(held_d);
        end
        if (draw_done_d) begin
            draw_done_d = 1'b0;
            cnt_d = 0;
        end else if (!draw_en_d) begin
            cnt_d = 0;
        end else begin
            cnt_d++;
            if (cnt_d == 5) draw_done_d = 1'b1;
        end
        done_prev_d = draw_done_d;
        en_prev_d = draw_en_d;
        if (frame_done_d) fd_d++;
        if (pass_pulse_d) pass_d++;
        if (overrun_d) ovr_d++;
    end

    // Drawer model and request logger, SPEED=10 instance
    req_t log_f[$];
    req_t held_f;
    int   cnt_f = 0;
    logic en_prev_f = 1'b0, done_prev_f = 1'b0;

    always @(negedge clk) begin
        if (done_prev_f) check("fast_en_drop_after_done", 32'(draw_en_f), 32'd0);
        if (draw_en_f && en_prev_f) check("fast_req_stable", 32'({pipe_x_f, pipe_y_f, pix_color_f}), 32'(held_f));
        if (draw_en_f && !en_prev_f) begin
            held_f = {pipe_x_f, pipe_y_f, pix_color_f};
            log_f.push_back(held_f);
        end
        if (draw_done_f) begin
            draw_done_f = 1'b0;
            cnt_f = 0;
        end else if (!draw_en_f) begin
            cnt_f = 0;
        end else begin
            cnt_f++;
            if (cnt_f == 5) draw_done_f = 1'b1;
        end
        done_prev_f = draw_done_f;
        en_prev_f = draw_en_f;
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy_d || busy_f) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 2000), 32'd1);
        @(negedge clk);
    endtask

    task automatic do_frame(input string tag);
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        int b, b71, b72, fd0, n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_draw_en", 32'(draw_en_d), 32'd0);
        check("rst_pipe_x", 32'(pipe_x_d), 32'd0);
        check("rst_pipe_y", 32'(pipe_y_d), 32'd0);
        check("rst_outs", 32'({pix_color_d, busy_d, frame_done_d, pass_pulse_d, overrun_d}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Frame 1: only slot 0 becomes visible -> single draw
        do_frame("f1_timeout");
        check("f1_req_count", 32'(log_d.size()), 32'd1);
        check("f1_req0", 32'(log_d[0]), 32'(mk(709, 160, 1)));
        check("f1_frame_done", 32'(fd_d), 32'd1);
        check("f1_busy", 32'(busy_d), 32'd0);

        // Frame 2: erase then draw
        do_frame("f2_timeout");
        check("f2_req_count", 32'(log_d.size()), 32'd3);
        check("f2_erase", 32'(log_d[1]), 32'(mk(709, 160, 0)));
        check("f2_draw", 32'(log_d[2]), 32'(mk(708, 160, 1)));

        // Frames 3..511: SPEED=10 wrap around frames 71-73, default pass at frame 511
        b71 = 0;
        b72 = 0;
        for (int f = 3; f <= 511; f++) begin
            if (f == 71) b71 = log_f.size();
            if (f == 72) b72 = log_f.size();
            if (f == 73) b = log_f.size();
            if (f == 511) begin
                check("pass_none_before_511", 32'(pass_d), 32'd0);
                b = log_d.size();
            end
            do_frame("frame_timeout");
            if (f == 71) begin
                check("fast_f71_erase", 32'(log_f[b71]), 32'(mk(10, 160, 0)));
                check("fast_f71_draw", 32'(log_f[b71+1]), 32'(mk(0, 160, 1)));
            end
            if (f == 72) begin
                check("fast_f72_count", 32'(log_f.size() - b72), 32'd5);
                check("fast_f72_erase0", 32'(log_f[b72]), 32'(mk(0, 160, 0)));
                check("fast_f72_slot1_erase", 32'(log_f[b72+1]), 32'(mk(240, 240, 0)));
                check("fast_f72_last", 32'(log_f[b72+4]), 32'(mk(470, 320, 1)));
            end
            if (f == 73) check("fast_f73_respawn", 32'(log_f[b]), 32'(mk(700, 192, 1)));
        end
        check("pass_once_511", 32'(pass_d), 32'd1);
        check("f511_erase", 32'(log_d[b]), 32'(mk(200, 160, 0)));
        check("f511_draw", 32'(log_d[b+1]), 32'(mk(199, 160, 1)));
        check("ovr_none_yet", 32'(ovr_d), 32'd0);

        // Frame 512 with two frame_start pulses while busy
        b = log_d.size();
        fd0 = fd_d;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        repeat (3) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        repeat (2) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        wait_idle("ovr_timeout");
        check("ovr_count", 32'(ovr_d), 32'd2);
        check("ovr_frame_done", 32'(fd_d - fd0), 32'd1);
        check("ovr_req_count", 32'(log_d.size() - b), 32'd6);
        check("ovr_req0", 32'(log_d[b]), 32'(mk(199, 160, 0)));
        check("ovr_req1", 32'(log_d[b+1]), 32'(mk(198, 160, 1)));
        check("ovr_req5", 32'(log_d[b+5]), 32'(mk(678, 320, 1)));

        // run=0: frame_start ignored, slots frozen
        b = log_d.size();
        fd0 = fd_d;
        run = 1'b0;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        check("run0_busy", 32'(busy_d), 32'd0);
        repeat (20) @(negedge clk);
        check("run0_no_req", 32'(log_d.size() - b), 32'd0);
        check("run0_no_done", 32'(fd_d - fd0), 32'd0);
        run = 1'b1;
        do_frame("run1_timeout");
        check("run1_erase", 32'(log_d[b]), 32'(mk(198, 160, 0)));
        check("run1_draw", 32'(log_d[b+1]), 32'(mk(197, 160, 1)));

        // Reset during an active request
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        n = 0;
        while (!draw_en_d && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_wait", 32'(n < 100), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_draw_en", 32'(draw_en_d), 32'd0);
        check("rst_mid_busy", 32'(busy_d), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        b = log_d.size();
        fd0 = fd_d;
        do_frame("post_rst_timeout");
        check("post_rst_req_count", 32'(log_d.size() - b), 32'd1);
        check("post_rst_req0", 32'(log_d[b]), 32'(mk(709, 160, 1)));
        check("post_rst_frame_done", 32'(fd_d - fd0), 32'd1);
        check("post_rst_busy", 32'(busy_d), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
